// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op codes, FSM states
// and the combinational arithmetic used to form the pending {hi,lo} result.
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } md_state_e;

    // Returns {hi,lo}. Signed divide works on magnitudes so that 0x80000000 / -1
    // wraps to 0x80000000 instead of trapping.
    function automatic logic [63:0] md_compute(md_op_e op, logic [31:0] a, logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] q;
        logic [31:0] r;
        logic [63:0] res;
        ea  = '0;
        eb  = '0;
        ma  = '0;
        mb  = '0;
        q   = '0;
        r   = '0;
        res = '0;
        case (op)
            MDU_MULT: begin
                ea  = {{32{a[31]}}, a};
                eb  = {{32{b[31]}}, b};
                res = ea * eb;
            end
            MDU_MULTU: begin
                ea  = {32'd0, a};
                eb  = {32'd0, b};
                res = ea * eb;
            end
            MDU_DIV: begin
                if (b == '0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else begin
                    ma  = a[31] ? -a : a;
                    mb  = b[31] ? -b : b;
                    q   = ma / mb;
                    r   = ma % mb;
                    res = {(a[31] ? -r : r), ((a[31] ^ b[31]) ? -q : q)};
                end
            end
            MDU_DIVU: begin
                if (b == '0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else begin
                    res = {a % b, a / b};
                end
            end
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit with HI/LO registers. Results are computed at the
// start edge and held pending until the fixed latency has elapsed.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

    md_state_e        state;
    logic [CNT_W-1:0] count;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    md_op_e           op_e;
    logic [63:0]      result;

    assign op_e   = md_op_e'(op);
    assign result = md_compute(op_e, a, b);
    assign busy   = (state == S_BUSY);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            count  <= '0;
            res_hi <= '0;
            res_lo <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        case (op_e)
                            MDU_MULT, MDU_MULTU: begin
                                {res_hi, res_lo} <= result;
                                count            <= MULT_LAST;
                                state            <= S_BUSY;
                            end
                            MDU_DIV, MDU_DIVU: begin
                                {res_hi, res_lo} <= result;
                                count            <= DIV_LAST;
                                state            <= S_BUSY;
                            end
                            MDU_MTHI: hi <= a;
                            MDU_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                S_BUSY: begin
                    // start is deliberately ignored here; ID stalls MD ops on busy|start
                    if (count == '0) begin
                        hi    <= res_hi;
                        lo    <= res_lo;
                        state <= S_IDLE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed ops push expected {hi,lo} and
// latency; a negedge monitor checks them when busy falls.
module tb_mult_div_unit;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    mult_div_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10),
        .CNT_W      (4)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int          cycles;
    } exp_t;

    exp_t        sb[$];
    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] cur_hi  = '0;
    logic [31:0] cur_lo  = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, req);
    endtask

    // Monitor: hold check during busy, result/latency check on busy falling
    logic prev_busy = 1'b0;
    int   bcnt      = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_busy = 1'b0;
            bcnt      = 0;
        end else begin
            if (busy) begin
                bcnt++;
                if (sb.size() > 0)
                    chk({sb[0].name, " hold"}, {hi, lo}, {sb[0].old_hi, sb[0].old_lo});
            end else if (prev_busy) begin
                if (sb.size() == 0) begin
                    chk("unexpected completion", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk({e.name, " hi"}, {32'd0, hi}, {32'd0, e.hi});
                    chk({e.name, " lo"}, {32'd0, lo}, {32'd0, e.lo});
                    chk({e.name, " latency"}, 64'(bcnt), 64'(e.cycles));
                end
                bcnt = 0;
            end
            prev_busy = busy;
        end
    end

    // Called at posedge+1; issues a one-cycle start and queues the expectation
    task automatic issue(input string nm, input logic [2:0] o, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el,
                         input int cyc);
        exp_t e;
        e.name   = nm;
        e.hi     = eh;
        e.lo     = el;
        e.old_hi = cur_hi;
        e.old_lo = cur_lo;
        e.cycles = cyc;
        sb.push_back(e);
        cur_hi = eh;
        cur_lo = el;
        start  = 1'b1;
        op     = o;
        a      = av;
        b      = bv;
        @(posedge clk) #1;
        start  = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk({nm, " busy cleared"}, {63'd0, busy}, 64'd0);
        @(posedge clk) #1;
    endtask

    task automatic run(input string nm, input logic [2:0] o, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el,
                       input int cyc);
        issue(nm, o, av, bv, eh, el, cyc);
        wait_idle(nm);
    endtask

    task automatic pulse(input logic [2:0] o, input logic [31:0] av);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = '0;
        @(posedge clk) #1;
        start = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        op      = '0;
        a       = '0;
        b       = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        chk("reset hi/lo", {hi, lo}, 64'd0);
        chk("reset busy", {63'd0, busy}, 64'd0);

        run("mult -2*3",        3'd0, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        run("multu max*max",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5);
        run("multu 2^16*2^16",  3'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 5);
        run("div -7/2",         3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        run("div 7/-2",         3'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10);
        run("divu 5/0",         3'd3, 32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF, 10);
        run("div -9/0",         3'd2, 32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFF7, 32'hFFFF_FFFF, 10);
        run("div min/-1",       3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10);

        // MTLO issued in busy cycle 2 must be dropped
        issue("mult 7*-3 w/ mtlo", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5);
        @(posedge clk) #1;
        pulse(3'd5, 32'h0000_1234);
        wait_idle("mult 7*-3 w/ mtlo");

        pulse(3'd4, 32'h0000_ABCD);
        chk("mthi hi", {32'd0, hi}, 64'h0000_ABCD);
        chk("mthi lo kept", {32'd0, lo}, 64'h0000_0000_FFFF_FFEB);
        chk("mthi busy", {63'd0, busy}, 64'd0);
        pulse(3'd5, 32'h0000_1234);
        chk("mtlo lo", {32'd0, lo}, 64'h0000_1234);
        pulse(3'd6, 32'h0000_DEAD);
        chk("reserved op", {hi, lo, 31'd0, busy}, {32'h0000_ABCD, 32'h0000_1234, 32'd0});
        cur_hi = 32'h0000_ABCD;
        cur_lo = 32'h0000_1234;

        // Abort a divide by reset in busy cycle 4
        start = 1'b1;
        op    = 3'd2;
        a     = 32'd100;
        b     = 32'd7;
        @(posedge clk) #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk) #1;
        reset_n = 1'b1;
        chk("abort hi/lo", {hi, lo}, 64'd0);
        chk("abort busy", {63'd0, busy}, 64'd0);
        cur_hi = '0;
        cur_lo = '0;
        run("divu 100/7 after reset", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 10);
        repeat (12) @(posedge clk);
        #1;
        chk("no late write", {hi, lo}, {32'd2, 32'd14});

        chk("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1);
    end

endmodule
